// File: rtl/sysid_check_sequencer_pkg.sv
// Shared types and constants for the system-ID check sequencer.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    FINISH
  } state_e;

  // Word select on the system-ID slave
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Width of the consecutive-waitrequest counter
  localparam int TO_W = 16;

endpackage

// File: rtl/sysid_check_sequencer_if.sv
// Avalon-MM read-only bus between the check sequencer and the system-ID slave.
interface sysid_check_sequencer_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/sysid_avalon_reader.sv
// Single-word Avalon-MM reader: issues one read strobe per launch, aborts
// after TIMEOUT consecutive stall cycles and waits READ_LATENCY cycles for
// data after acceptance. data_valid_o/timed_out_o are single-cycle strobes.
module sysid_avalon_reader
  import sysid_check_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     launch_i,
  input  logic                     addr_i,
  sysid_check_sequencer_if.master  av,
  output logic                     accept_o,
  output logic                     data_valid_o,
  output logic [31:0]              data_o,
  output logic                     timed_out_o
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]      LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  logic            read_q;
  logic            addr_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            lat_q;
  logic [1:0]      lat_cnt_q;

  logic accept;
  logic timed_out;

  assign accept    = read_q & ~av.av_waitrequest;
  assign timed_out = read_q & av.av_waitrequest & (to_cnt_q == TO_LAST);

  assign accept_o     = accept;
  assign timed_out_o  = timed_out;
  assign data_o       = av.av_readdata;
  assign data_valid_o = (READ_LATENCY == 0) ? accept : (lat_q && (lat_cnt_q == LAT_LAST));

  assign av.av_read    = read_q;
  assign av.av_address = addr_q;

  // Read strobe, stall counter and post-accept latency counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      to_cnt_q  <= '0;
      lat_q     <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      // A launch may coincide with the previous word's accept when there is
      // no read latency; the strobe then simply stays high on the new word.
      if (launch_i) begin
        read_q   <= 1'b1;
        addr_q   <= addr_i;
        to_cnt_q <= '0;
      end else if (accept) begin
        read_q   <= 1'b0;
        to_cnt_q <= '0;
      end else if (timed_out) begin
        read_q   <= 1'b0;
        to_cnt_q <= '0;
      end else if (read_q) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if ((READ_LATENCY > 0) && accept) begin
        lat_q     <= 1'b1;
        lat_cnt_q <= '0;
      end else if (lat_q) begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_q <= 1'b0;
        end else begin
          lat_cnt_q <= lat_cnt_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sysid_check_sequencer.sv
// Reads system-ID word 0 (ID) and word 1 (build timestamp) and compares both
// against expected values; result gates "system valid" and the boot loader.
// Optional build macro SYSID_CHECK_PERIODIC_EN adds a periodic re-check
// (PERIOD cycles) and a reset-only mismatch_sticky output.
module sysid_check_sequencer
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1457816465,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          AUTO_START   = 1'b1
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int unsigned PERIOD       = 50_000_000
`endif
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  sysid_check_sequencer_if.master av,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [31:0]             id_value,
  output logic [31:0]             ts_value
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  output logic                    mismatch_sticky
`endif
);

  state_e      state_q;
  logic        auto_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        id_mis_q;
  logic        ts_mis_q;
  logic        timeout_q;
  logic [31:0] id_value_q;
  logic [31:0] ts_value_q;

  logic        go;
  logic        rd_launch_d;
  logic        rd_addr_d;
  logic        rd_accept;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_timed_out;

  sysid_avalon_reader #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_reader (
    .clock        (clock),
    .reset_n      (reset_n),
    .launch_i     (rd_launch_d),
    .addr_i       (rd_addr_d),
    .av           (av),
    .accept_o     (rd_accept),
    .data_valid_o (rd_valid),
    .data_o       (rd_data),
    .timed_out_o  (rd_timed_out)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] per_cnt_q;
  logic        sticky_q;

  assign go              = start | auto_q | (per_cnt_q == 32'(PERIOD - 1));
  assign mismatch_sticky = sticky_q;

  // Free-running period counter restarted by each completed check; sticky
  // failure flag survives later passing checks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      per_cnt_q <= done_q ? 32'd0 : per_cnt_q + 32'd1;
      if (done_q && !pass_q) begin
        sticky_q <= 1'b1;
      end
    end
  end
`else
  assign go = start | auto_q;
`endif

  // Launch the reader when leaving IDLE and again once word 0 has arrived
  always_comb begin
    rd_launch_d = 1'b0;
    rd_addr_d   = ADDR_ID;
    if ((state_q == IDLE) && go) begin
      rd_launch_d = 1'b1;
    end else if (((state_q == RD_ID) || (state_q == LAT_ID)) && rd_valid) begin
      rd_launch_d = 1'b1;
      rd_addr_d   = ADDR_TS;
    end
  end

  // Check sequencer FSM with registered status outputs; flags are computed
  // on entry to FINISH so they are valid together with the done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      auto_q     <= AUTO_START;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_mis_q   <= 1'b0;
      ts_mis_q   <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      auto_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q   <= RD_ID;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            id_mis_q  <= 1'b0;
            ts_mis_q  <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        RD_ID, LAT_ID: begin
          if (rd_timed_out) begin
            // Neither word read: both mismatch flags stay clear
            state_q   <= FINISH;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (rd_valid) begin
            id_value_q <= rd_data;
            state_q    <= RD_TS;
          end else if (rd_accept) begin
            state_q <= LAT_ID;
          end
        end
        RD_TS, LAT_TS: begin
          if (rd_timed_out) begin
            // ID was read, so its comparison still stands
            state_q   <= FINISH;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            id_mis_q  <= (id_value_q != EXPECTED_ID);
          end else if (rd_valid) begin
            ts_value_q <= rd_data;
            state_q    <= FINISH;
            done_q     <= 1'b1;
            id_mis_q   <= (id_value_q != EXPECTED_ID);
            ts_mis_q   <= (rd_data != EXPECTED_TS);
            pass_q     <= (id_value_q == EXPECTED_ID) && (rd_data == EXPECTED_TS);
          end else if (rd_accept) begin
            state_q <= LAT_TS;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
